counter_timeout: RTL and testbench

//  Parametrised player-response timer for the Genius game, the successor to the fixed 0..9 time counter.

---
 rtl/genius_timer_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 36 +++
 rtl/counter_timeout.sv | 124 ++++++++++++
 tb/tb_counter_timeout.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/genius_timer_pkg.sv
// Shared encodings for the Genius player-response timer.
// State codes and MODE values used by counter_timeout.
package genius_timer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_PAUSE   = 2'b10;
  localparam logic [1:0] ST_EXPIRED = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_RUN     = ST_RUN,
    S_PAUSE   = ST_PAUSE,
    S_EXPIRED = ST_EXPIRED
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLKT into ticks: one tick every PRESCALE running cycles.
// Ports: CLKT, R (async high), run, clr (sync zero) -> tick.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic CLKT,
  input  logic R,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] TOP = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          wrap;

  // With PRESCALE=1 the counter never leaves 0, so tick == run.
  assign wrap = (cnt_q == TOP);
  assign tick = run && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = wrap ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge CLKT or posedge R) begin
    if (R) cnt_q <= '0;
    else   cnt_q <= cnt_d;
  end

endmodule

// File: rtl/counter_timeout.sv
// Genius player-response timer: counts ticks to a latched limit.
// In: CLKT R E RESTART MODE LIMIT; out: TEMPO end_time EXPIRED WARN BUSY.
module counter_timeout
  import genius_timer_pkg::*;
#(
  parameter int W          = 4,
  parameter int PRESCALE   = 1,
  parameter int WARN_TICKS = 2
) (
  input  logic         CLKT,
  input  logic         R,
  input  logic         E,
  input  logic         RESTART,
  input  logic         MODE,
  input  logic [W-1:0] LIMIT,
  output logic [W-1:0] TEMPO,
  output logic         end_time,
  output logic         EXPIRED,
  output logic         WARN,
  output logic         BUSY
);

  state_e       state_q, state_d;
  logic [W-1:0] tempo_q, tempo_d;
  logic [W-1:0] limit_q, limit_d;
  logic         end_q, end_d;
  logic         exp_q, exp_d;
  logic [W-1:0] lim_in;
  logic         active, run, clr, tick, last;
  logic [31:0]  lim32, wt32, th32;

  assign lim_in = (LIMIT == '0) ? W'(1) : LIMIT;
  assign active = (state_q == S_RUN) || (state_q == S_PAUSE);
  // The resume cycle in PAUSE counts, so an N-cycle pause
  // delays expiry by exactly N cycles.
  assign run    = active && E && !RESTART;
  assign clr    = RESTART || (state_q == S_IDLE);
  assign last   = (tempo_q == limit_q - W'(1));

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .CLKT(CLKT),
    .R   (R),
    .run (run),
    .clr (clr),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    tempo_d = tempo_q;
    limit_d = limit_q;
    end_d   = 1'b0;
    exp_d   = exp_q;
    if (RESTART) begin
      tempo_d = '0;
      exp_d   = 1'b0;
      limit_d = lim_in;
      state_d = E ? S_RUN : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (E) begin
            state_d = S_RUN;
            limit_d = lim_in;
            tempo_d = '0;
          end
        end
        S_RUN, S_PAUSE: begin
          if (tick) begin
            state_d = S_RUN;
            if (last) begin
              tempo_d = '0;
              end_d   = 1'b1;
              if (MODE == MODE_ONESHOT) begin
                state_d = S_EXPIRED;
                exp_d   = 1'b1;
              end
            end else begin
              tempo_d = tempo_q + W'(1);
            end
          end else if (!E) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
        S_EXPIRED: begin
          tempo_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLKT or posedge R) begin
    if (R) begin
      state_q <= S_IDLE;
      tempo_q <= '0;
      limit_q <= W'(1);
      end_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tempo_q <= tempo_d;
      limit_q <= limit_d;
      end_q   <= end_d;
      exp_q   <= exp_d;
    end
  end

  // Warning threshold saturates at 0 for short limits.
  assign lim32 = 32'(limit_q);
  assign wt32  = 32'(WARN_TICKS);
  assign th32  = (lim32 > wt32) ? lim32 - wt32 : '0;

  assign TEMPO    = tempo_q;
  assign end_time = end_q;
  assign EXPIRED  = exp_q;
  assign BUSY     = active;
  assign WARN     = active && (32'(tempo_q) >= th32);

endmodule

// File: tb/tb_counter_timeout.sv
// Scoreboard bench for counter_timeout (PRESCALE=1 and PRESCALE=4).
// Expected end_time cycle stamps are queued; a monitor pops on each pulse.
module tb_counter_timeout;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         e1 = 1'b0;
  logic         e4 = 1'b0;
  logic         rs = 1'b0;
  logic         mode = 1'b1;
  logic [W-1:0] lim = 4'd9;
  logic [W-1:0] t1, t4;
  logic         end1, end4, ex1, ex4, w1, w4, b1, b4;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int q1[$];
  int q4[$];
  int c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_timeout #(.W(W), .PRESCALE(1), .WARN_TICKS(2)) u1 (
    .CLKT(clk), .R(r), .E(e1), .RESTART(rs), .MODE(mode),
    .LIMIT(lim), .TEMPO(t1), .end_time(end1), .EXPIRED(ex1),
    .WARN(w1), .BUSY(b1)
  );

  counter_timeout #(.W(W), .PRESCALE(4), .WARN_TICKS(2)) u4 (
    .CLKT(clk), .R(r), .E(e4), .RESTART(rs), .MODE(mode),
    .LIMIT(lim), .TEMPO(t4), .end_time(end4), .EXPIRED(ex4),
    .WARN(w4), .BUSY(b4)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every end_time pulse must match the next queued stamp.
  always @(negedge clk) begin
    if (!r) begin
      if (end1) begin
        if (q1.size() == 0) chk("end1_unexpected", 1, 0);
        else chk("end1_cycle", cyc, q1.pop_front());
      end
      if (end4) begin
        if (q4.size() == 0) chk("end4_unexpected", 1, 0);
        else chk("end4_cycle", cyc, q4.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_tempo", int'(t1), 0);
    chk("rst_end", int'(end1), 0);
    chk("rst_exp", int'(ex1), 0);
    chk("rst_busy", int'(b1), 0);
    chk("rst_warn", int'(w1), 0);
    chk("rst_busy4", int'(b4), 0);
    r = 1'b0;

    // Legacy rate, LIMIT=9, auto-reload
    @(negedge clk);
    mode = 1'b1; lim = 4'd9; e1 = 1'b1; c = cyc;
    q1.push_back(c + 10);
    q1.push_back(c + 19);
    q1.push_back(c + 28);
    for (int j = 0; j < 28; j++) begin
      @(negedge clk);
      chk("legacy_tempo", int'(t1), j % 9);
      chk("legacy_warn", int'(w1), int'((j % 9) >= 7));
    end
    e1 = 1'b0; rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
    chk("stop_busy", int'(b1), 0);

    // Async reset mid-run at TEMPO=5
    lim = 4'd9; e1 = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_tempo", int'(t1), 5);
    #2 r = 1'b1;
    #1;
    chk("async_rst_tempo", int'(t1), 0);
    chk("async_rst_busy", int'(b1), 0);
    chk("async_rst_warn", int'(w1), 0);
    chk("async_rst_end", int'(end1), 0);
    @(negedge clk);
    r = 1'b0; e1 = 1'b0;

    // Pause 10 cycles at TEMPO=2, LIMIT=5
    @(negedge clk);
    lim = 4'd5; e1 = 1'b1; c = cyc;
    q1.push_back(c + 16);
    repeat (3) @(negedge clk);
    chk("pause_pre", int'(t1), 2);
    e1 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("pause_hold", int'(t1), 2);
    end
    chk("pause_busy", int'(b1), 1);
    e1 = 1'b1;
    @(negedge clk);
    chk("resume_t3", int'(t1), 3);
    @(negedge clk);
    chk("resume_t4", int'(t1), 4);
    @(negedge clk);
    chk("resume_wrap", int'(t1), 0);
    e1 = 1'b0; rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;

    // Restart on the final-tick cycle relatches LIMIT=5
    lim = 4'd3; e1 = 1'b1; c = cyc;
    repeat (3) @(negedge clk);
    chk("rvx_pre", int'(t1), 2);
    rs = 1'b1; lim = 4'd5;
    q1.push_back(c + 9);
    @(negedge clk);
    rs = 1'b0;
    chk("rvx_tempo", int'(t1), 0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk("rvx_newlim", int'(t1), j % 5);
    end
    e1 = 1'b0; rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;

    // LIMIT=0 behaves as 1: expiry every tick
    lim = 4'd0; e1 = 1'b1; c = cyc;
    q1.push_back(c + 2);
    q1.push_back(c + 3);
    repeat (3) @(negedge clk);
    chk("lim0_tempo", int'(t1), 0);
    e1 = 1'b0; rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;

    // LIMIT=15: TEMPO peaks at 14
    lim = 4'd15; e1 = 1'b1; c = cyc;
    q1.push_back(c + 16);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("lim15_tempo", int'(t1), j % 15);
      chk("lim15_warn", int'(w1), int'((j % 15) >= 13));
    end
    e1 = 1'b0; rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;

    // One-shot with PRESCALE=4, LIMIT=3
    mode = 1'b0; lim = 4'd3; e4 = 1'b1; c = cyc;
    q4.push_back(c + 13);
    repeat (12) @(negedge clk);
    chk("os_tempo", int'(t4), 2);
    chk("os_warn", int'(w4), 1);
    chk("os_exp_pre", int'(ex4), 0);
    @(negedge clk);
    chk("os_exp", int'(ex4), 1);
    chk("os_tempo0", int'(t4), 0);
    chk("os_busy", int'(b4), 0);
    repeat (5) @(negedge clk);
    chk("os_exp_held", int'(ex4), 1);
    chk("os_warn_off", int'(w4), 0);
    rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
    chk("os_rst_exp", int'(ex4), 0);
    chk("os_rst_busy", int'(b4), 1);
    chk("os_rst_tempo", int'(t4), 0);
    e4 = 1'b0; rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
    chk("os_idle", int'(b4), 0);

    repeat (3) @(negedge clk);
    chk("q1_left", q1.size(), 0);
    chk("q4_left", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
